// File: rtl/fpga_conf_spi.sv
`default_nettype none
// ============================================================================
// Module   : fpga_conf_spi
// Function : Oversampled SPI slave writing a bank of configuration registers,
//            with glitch-safe deferred apply of register 0 and readback on miso.
// Revision : 1.0
// ============================================================================
module fpga_conf_spi #(
    parameter int FRAME_W     = 16,
    parameter int CMD_W       = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       ck_1356meg,
    input  logic                       nrst,
    input  logic                       spck,
    input  logic                       ncs,
    input  logic                       mosi,
    output logic                       miso,
    input  logic                       mode_safe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [DATA_W-1:0]          conf_word,
    output logic [NUM_REGS-1:0]        upd_strobe,
    output logic                       frame_err,
    output logic [7:0]                 err_cnt
);

    localparam int                 c_CNT_W    = $clog2(FRAME_W + 2);
    localparam int                 c_SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [DATA_W-1:0]  c_CONF_RST = DATA_W'(8'hE0);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(FRAME_W + 1);
    localparam logic [CMD_W-1:0]   c_CMD_PEND = CMD_W'(1);
    localparam logic [CMD_W-1:0]   c_CMD_CLR  = CMD_W'(14);
    localparam logic [CMD_W-1:0]   c_CMD_RSEL = CMD_W'(15);

    logic [SYNC_STAGES-1:0] r_spck_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_warm;
    logic                   r_spck_q;
    logic                   r_ncs_q;

    logic                   r_armed;
    logic                   r_active;
    logic [c_CNT_W-1:0]     r_bitcnt;
    logic [FRAME_W-1:0]     r_frame;
    logic [FRAME_W-1:0]     r_rd_shift;
    logic                   r_miso;
    logic                   r_dec_valid;
    logic [CMD_W-1:0]       r_dec_cmd;
    logic [DATA_W-1:0]      r_dec_payload;

    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [DATA_W-1:0]      r_pend;
    logic                   r_pend_valid;
    logic [NUM_REGS-1:0]    r_strobe;
    logic                   r_err;
    logic [7:0]             r_err_cnt;
    logic [c_SEL_W-1:0]     r_rd_sel;

    logic                   w_spck;
    logic                   w_ncs;
    logic                   w_mosi;
    logic                   w_warm;
    logic                   w_spck_rise;
    logic                   w_spck_fall;
    logic                   w_ncs_fall;
    logic                   w_ncs_rise;
    logic                   w_frame_bad;
    logic [FRAME_W-1:0]     w_rd_word;

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            r_spck_sync <= '0;
            r_ncs_sync  <= '1;
            r_mosi_sync <= '0;
            r_warm      <= '0;
            r_spck_q    <= 1'b0;
            r_ncs_q     <= 1'b1;
        end else begin
            r_spck_sync <= {r_spck_sync[SYNC_STAGES-2:0], spck};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
            r_spck_q    <= w_spck;
            r_ncs_q     <= w_ncs;
        end
    end

    assign w_spck      = r_spck_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_warm      = r_warm[SYNC_STAGES-1];
    assign w_spck_rise = w_spck & ~r_spck_q;
    assign w_spck_fall = ~w_spck & r_spck_q;
    // A select already low when reset releases is not a fresh frame start.
    assign w_ncs_fall  = r_armed & r_ncs_q & ~w_ncs;
    assign w_ncs_rise  = r_active & ~r_ncs_q & w_ncs;
    assign w_frame_bad = w_ncs_rise & (r_bitcnt != c_CNT_FULL);
    assign w_rd_word   = FRAME_W'(r_regs[r_rd_sel]) << (FRAME_W - DATA_W);

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            r_armed       <= 1'b0;
            r_active      <= 1'b0;
            r_bitcnt      <= '0;
            r_frame       <= '0;
            r_rd_shift    <= '0;
            r_miso        <= 1'b0;
            r_dec_valid   <= 1'b0;
            r_dec_cmd     <= '0;
            r_dec_payload <= '0;
        end else begin
            r_dec_valid <= 1'b0;
            if (w_warm && w_ncs) begin
                r_armed <= 1'b1;
            end
            if (w_ncs_fall) begin
                r_active   <= 1'b1;
                r_bitcnt   <= '0;
                r_rd_shift <= w_rd_word;
            end else begin
                if (r_active && !w_ncs && w_spck_rise) begin
                    r_frame <= {r_frame[FRAME_W-2:0], w_mosi};
                    if (r_bitcnt != c_CNT_SAT) begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                if (r_active && !w_ncs && w_spck_fall) begin
                    r_rd_shift <= r_rd_shift << 1;
                end
            end
            if (w_ncs) begin
                r_miso <= 1'b0;
            end else if (r_active && w_spck_fall) begin
                r_miso <= r_rd_shift[FRAME_W-1];
            end
            if (w_ncs_rise) begin
                r_active <= 1'b0;
                if (r_bitcnt == c_CNT_FULL) begin
                    r_dec_valid   <= 1'b1;
                    r_dec_cmd     <= r_frame[FRAME_W-1 -: CMD_W];
                    r_dec_payload <= r_frame[DATA_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            r_regs[0] <= c_CONF_RST;
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_strobe     <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_rd_sel     <= '0;
        end else begin
            r_strobe <= '0;
            // Apply first so a same-cycle k=1 decode re-arms the pending slot.
            if (r_pend_valid && mode_safe) begin
                r_regs[0]    <= r_pend;
                r_strobe[0]  <= 1'b1;
                r_pend_valid <= 1'b0;
            end
            if (r_dec_valid) begin
                if (r_dec_cmd == c_CMD_PEND) begin
                    r_pend       <= r_dec_payload;
                    r_pend_valid <= 1'b1;
                end
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (r_dec_cmd == CMD_W'(i + 1)) begin
                        r_regs[i]   <= r_dec_payload;
                        r_strobe[i] <= 1'b1;
                    end
                end
                if (r_dec_cmd == c_CMD_CLR) begin
                    r_err     <= 1'b0;
                    r_err_cnt <= '0;
                end
                if (r_dec_cmd == c_CMD_RSEL) begin
                    r_rd_sel <= c_SEL_W'(r_dec_payload % DATA_W'(NUM_REGS));
                end
            end
            if (w_frame_bad) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

    assign conf_word  = r_regs[0];
    assign upd_strobe = r_strobe;
    assign frame_err  = r_err;
    assign err_cnt    = r_err_cnt;
    assign miso       = r_miso;

endmodule
`default_nettype wire
